// File: rtl/demux_stream_scheduler_pkg.sv
// demux_stream_scheduler_pkg: shared state encoding and destination sizing for the demux scheduler
package demux_stream_scheduler_pkg;
    typedef enum logic {ST_IDLE, ST_ROUTE} state_t;
    localparam int NUM_DEST = 4;
    localparam int DEST_W = 2;
endpackage

// File: rtl/demux_stream_scheduler_rr_pick4.sv
// rr_pick4: first set bit of a 4-bit mask, scanning upward from ptr with wraparound
module rr_pick4
    import demux_stream_scheduler_pkg::*;
(
    input  logic [NUM_DEST-1:0] mask,
    input  logic [DEST_W-1:0]   ptr,
    output logic                found,
    output logic [DEST_W-1:0]   idx
);
    logic [DEST_W-1:0] k;
    // Scan farthest-first so the closest set bit to ptr is written last.
    always_comb begin
        found = |mask;
        idx = ptr;
        k = '0;
        for (int i = NUM_DEST - 1; i >= 0; i--) begin
            k = ptr + DEST_W'(i);
            if (mask[k]) idx = k;
        end
    end
endmodule

// File: rtl/demux_stream_scheduler.sv
// demux_stream_scheduler: packet-locked 1-to-4 stream steering with a one-entry output buffer
module demux_stream_scheduler
    import demux_stream_scheduler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DEST_W-1:0]   in_dest,
    input  logic                mode_rr,
    input  logic [NUM_DEST-1:0] dest_en,
    output logic [DATA_W-1:0]   out_data,
    output logic [NUM_DEST-1:0] out_valid,
    output logic                out_last,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic                busy,
    output logic [DEST_W-1:0]   cur_dest,
    output logic                pkt_done
);
    localparam int CNT_W = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    state_t state, state_nx;
    logic [DEST_W-1:0] rr_ptr, rr_idx, buf_dest, cand;
    logic [CNT_W-1:0] beat_cnt;
    logic rr_found, cand_ok, start, accept, drain, last_beat, buf_full;
    rr_pick4 u_pick (
        .mask (dest_en),
        .ptr  (rr_ptr),
        .found(rr_found),
        .idx  (rr_idx)
    );
    always_comb begin
        cand = mode_rr ? rr_idx : in_dest;
        cand_ok = mode_rr ? rr_found : dest_en[in_dest];
        start = state == ST_IDLE && in_valid && cand_ok;
        last_beat = beat_cnt == CNT_W'(PKT_LEN - 1);
        busy = state == ST_ROUTE;
        drain = buf_full && out_ready[buf_dest];
        in_ready = busy && (!buf_full || out_ready[buf_dest]);
        accept = in_valid && in_ready;
        pkt_done = accept && last_beat;
        out_valid = buf_full ? NUM_DEST'(1) << buf_dest : '0;
        state_nx = start ? ST_ROUTE : pkt_done ? ST_IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            rr_ptr <= '0;
            beat_cnt <= '0;
            cur_dest <= '0;
            buf_full <= 1'b0;
            buf_dest <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                cur_dest <= cand;
                beat_cnt <= '0;
            end
            // Buffer keeps its own destination so a pending last beat survives the next packet's selection.
            if (accept) begin
                buf_full <= 1'b1;
                buf_dest <= cur_dest;
                out_data <= in_data;
                out_last <= last_beat;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end else if (drain) begin
                buf_full <= 1'b0;
            end
            if (pkt_done) rr_ptr <= cur_dest + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_stream_scheduler.sv
// tb_demux_stream_scheduler: directed packets checked against a transaction-level scoreboard
module tb_demux_stream_scheduler;
    localparam int PKT_LEN = 4;
    typedef struct {logic [1:0] d; logic [7:0] data; logic last;} beat_t;
    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_ready, mode_rr = 1'b0, out_last, busy, pkt_done;
    logic [7:0] in_data = '0, out_data;
    logic [1:0] in_dest = '0, cur_dest;
    logic [3:0] dest_en = 4'hF, out_valid, out_ready = 4'hF;
    logic v1 = 1'b0, rdy1, ol1, busy1, pd1;
    logic [7:0] d1 = '0, od1;
    logic [3:0] ov1;
    logic [1:0] cd1;
    int total = 0, bad = 0, m_rr = 0;
    beat_t exp_q[$];

    demux_stream_scheduler #(.DATA_W(8), .PKT_LEN(PKT_LEN)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .mode_rr(mode_rr), .dest_en(dest_en), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .busy(busy),
        .cur_dest(cur_dest), .pkt_done(pkt_done)
    );
    demux_stream_scheduler #(.DATA_W(8), .PKT_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .in_dest(2'd0), .mode_rr(1'b1), .dest_en(4'hF), .out_data(od1),
        .out_valid(ov1), .out_last(ol1), .out_ready(4'hF), .busy(busy1),
        .cur_dest(cd1), .pkt_done(pd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic pick(input logic rr, input logic [1:0] d, input logic [3:0] en,
                                  input int ptr, output logic [1:0] idx);
        idx = d;
        if (!rr) return en[d];
        for (int i = 0; i < 4; i++)
            if (en[(ptr + i) % 4]) begin
                idx = 2'((ptr + i) % 4);
                return 1'b1;
            end
        return 1'b0;
    endfunction

    // Called at a negedge; returns at a negedge after the last beat (or after an abort by reset).
    task automatic send(input logic rr, input logic [1:0] d, input logic [3:0] en, input logic [7:0] base,
                        input int stall_beat, input int abort_after, output logic [1:0] dd);
        int w;
        logic ok;
        ok = pick(rr, d, en, m_rr, dd);
        chk("model_found", ok, 1);
        in_valid = 1'b1; mode_rr = rr; in_dest = d; dest_en = en;
        for (int b = 0; b < PKT_LEN; b++) begin
            in_data = base + 8'(b);
            w = 0;
            #2;
            while (!in_ready && w < 40) begin @(negedge clk); #2; w++; end
            if (!in_ready) begin chk("accept_timeout", 0, 1); in_valid = 1'b0; return; end
            if (b == 0) chk("start_wait", w, 1);
            exp_q.push_back('{dd, in_data, b == PKT_LEN - 1});
            @(negedge clk);
            if (b == 0) begin mode_rr = ~rr; in_dest = ~d; dest_en = ~en; end
            if (b == stall_beat) begin
                out_ready = ~(4'b1 << dd);
                for (int s = 0; s < 3; s++) begin
                    #2;
                    chk("stall_in_ready", in_ready, 0);
                    out_ready[dd ^ 2'd1] = ~out_ready[dd ^ 2'd1];
                    @(negedge clk);
                end
                out_ready = 4'hF;
            end
            if (b + 1 == abort_after) begin
                #1 reset = 1'b1; in_valid = 1'b0;
                #1;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pkt_done", pkt_done, 0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0; m_rr = 0;
                return;
            end
        end
        in_valid = 1'b0;
        m_rr = (dd + 1) % 4;
    endtask

    // Scoreboard: every consumed beat, plus latency, hold, pkt_done and gap rules each cycle.
    initial begin
        logic acc, acc_p, last_p, stall_p, pl;
        logic [7:0] acc_d, pd;
        logic [3:0] pv;
        logic [1:0] sel;
        int cnt;
        beat_t e;
        acc_p = 0; last_p = 0; stall_p = 0; cnt = 0; acc_d = '0; pd = '0; pv = '0; pl = 0; sel = '0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                exp_q.delete(); cnt = 0; acc_p = 0; last_p = 0; stall_p = 0;
                continue;
            end
            chk("onehot", $countones(out_valid) <= 1, 1);
            if (acc_p) begin
                chk("lat_valid", out_valid != 0, 1);
                chk("lat_data", out_data, acc_d);
            end
            if (last_p) chk("gap_in_ready", in_ready, 0);
            if (stall_p) begin
                chk("hold_valid", out_valid, pv);
                chk("hold_data", out_data, pd);
                chk("hold_last", out_last, pl);
            end
            acc = in_valid && in_ready;
            chk("pkt_done", pkt_done, acc && cnt == PKT_LEN - 1);
            for (int i = 0; i < 4; i++) if (out_valid[i]) sel = 2'(i);
            if (out_valid != 0 && out_ready[sel]) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_dest", sel, e.d);
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                end
            end
            stall_p = out_valid != 0 && !out_ready[sel];
            pv = out_valid; pd = out_data; pl = out_last;
            acc_p = acc; acc_d = in_data;
            last_p = acc && cnt == PKT_LEN - 1;
            if (acc) cnt = (cnt + 1) % PKT_LEN;
        end
    end

    initial begin
        logic [1:0] dd, idx;
        int exp_rr[6] = '{0, 1, 2, 3, 1, 3};
        int exp1[5] = '{0, 1, 2, 3, 0};
        int w;
        chk("pin_rr_wrap", pick(1, 0, 4'b1010, 3, idx), 1);
        chk("pin_rr_wrap_idx", idx, 3);
        chk("pin_rr_skip_idx", {31'd0, pick(1, 0, 4'b1010, 2, idx)} + {30'd0, idx}, 4);
        chk("pin_addr_off", pick(0, 3, 4'b0111, 0, idx), 0);
        @(negedge clk);
        #2;
        chk("rst0_out_valid", out_valid, 0);
        chk("rst0_out_data", out_data, 0);
        chk("rst0_out_last", out_last, 0);
        chk("rst0_in_ready", in_ready, 0);
        chk("rst0_busy", busy, 0);
        chk("rst0_cur_dest", cur_dest, 0);
        chk("rst0_pkt_done", pkt_done, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 6; p++) begin
            send(1, 0, p < 3 ? 4'hF : 4'b1010, 8'(8'h20 + 16 * p), -1, 0, dd);
            chk("rr_dest", dd, exp_rr[p]);
        end
        send(0, 2, 4'hF, 8'hA0, -1, 0, dd);
        chk("addr_dest", dd, 2);
        send(0, 1, 4'hF, 8'h10, 1, 0, dd);
        in_valid = 1'b1; mode_rr = 1'b0; in_dest = 2'd3; dest_en = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("dis_in_ready", in_ready, 0);
            chk("dis_busy", busy, 0);
            @(negedge clk);
        end
        send(0, 3, 4'hF, 8'h30, -1, 0, dd);
        chk("dis_dest", dd, 3);
        send(1, 0, 4'hF, 8'h50, -1, 2, dd);
        send(1, 0, 4'hF, 8'h60, -1, 0, dd);
        chk("post_rst_dest", dd, 0);
        repeat (3) @(negedge clk);
        chk("drained", exp_q.size(), 0);
        for (int k = 0; k < 5; k++) begin
            v1 = 1'b1; d1 = 8'(8'h80 + k); w = 0;
            #2;
            while (!rdy1 && w < 20) begin @(negedge clk); #2; w++; end
            chk("p1_done", pd1, 1);
            @(negedge clk);
            v1 = 1'b0;
            #2;
            chk("p1_dest", ov1, 4'b1 << exp1[k]);
            chk("p1_last", ol1, 1);
            chk("p1_data", od1, 8'(8'h80 + k));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
